l2_req_q: RTL and testbench
===========================

// Module: l2_req_q
// PURPOSE
// - Per-requester request queue between a cache (DC or IC) and one L2 port.
// - Buffers t_mem_req_pkt traffic under a valid/ready handshake; issues at most one request per cycle to L2.
// - Throttles reads to MAX_OUTST in flight.
// - Returns L2 responses to the requester through a one-cycle register.
// - L2 accepts every valid request unconditionally and has no back-pressure, so all flow control lives here.
// PARAMETERS
// - DEPTH      4  FIFO entries (power of 2, >=2)
// - MAX_OUTST  2  max reads issued without a response (>=1)
// PORTS
// - clk          in   1              clock
// - reset_n      in   1              asynchronous reset, active-low
// - req_pkt      in   t_mem_req_pkt  request from cache; .valid qualifies
// - req_rdy      out  1              queue can accept req_pkt this cycle
// - l2_req_pkt   out  t_mem_req_pkt  request to L2 (registered)
// - l2_rsp_pkt   in   t_mem_rsp_pkt  response from L2
// - rsp_pkt      out  t_mem_rsp_pkt  response to cache (registered)
// - drain        in   1              stop accepting; flush queue and in-flight reads
// - drained      out  1              FIFO empty and no reads outstanding
// BEHAVIOUR
// - Reset (reset_n=0, async): FIFO pointers, count and outst_cnt cleared.
//   - l2_req_pkt='0, rsp_pkt='0.
//   - req_rdy=0 while in reset; drained=1.
//   - Reset mid-operation discards all queued and in-flight state; late L2 responses after reset are dropped.
// - Enqueue:
//   - req_rdy = (count<DEPTH) & ~drain, driven from flops.
//   - Accept when req_pkt.valid & req_rdy; the entry is written at the clock edge.
//   - req_pkt.valid with req_rdy=0 is ignored; the requester must hold its request.
// - Pointers: log2(DEPTH)+1 bits, with the wrap bit compared for full/empty. Increment modulo 2*DEPTH.
// - Issue (combinational decision, registered output):
//   - Eligible when FIFO not empty and either head.op==MEM_OP_WRITE or outst_cnt<MAX_OUTST.
//   - If eligible: pop the head; l2_req_pkt<=head with valid=1.
//   - If not eligible: l2_req_pkt<='0, a single-cycle pulse per request.
//   - Strict in-order issue. A blocked read stalls the writes behind it; there is no reordering.
// - Latency: request accepted at cycle N appears on l2_req_pkt at N+2 at the earliest.
// - Push and pop in the same cycle: count unchanged; legal when full only if req_rdy was already high.
// - Outstanding counter:
//   - +1 when a MEM_OP_READ or MEM_OP_READ_INV is issued.
//   - -1 when l2_rsp_pkt.valid.
//   - Both in the same cycle: unchanged.
//   - Response while outst_cnt==0: the counter holds at 0 and `VASSERT fires under ASSERT.
// - Writes produce no response and never consume credit.
// - Response path: rsp_pkt<=l2_rsp_pkt when valid, else '0. Latency is 1 cycle; id and data pass through unmodified.
// - Drain:
//   - While drain=1: req_rdy=0; issue and the response path continue.
//   - drained=(count==0)&(outst_cnt==0), registered.
//   - drained rises the cycle after the last response is absorbed.
//   - Deasserting drain restores req_rdy on the next cycle.
// CONFIGURATION
// - L2Q_BYPASS_EN defined:
//   - Applies when the FIFO is empty and no pop occurs.
//   - An accepted req_pkt that is eligible is loaded directly into l2_req_pkt, visible at N+1, and never written to the FIFO.
//   - Ineligible requests are enqueued normally.
// - L2Q_BYPASS_EN undefined: every request passes through the FIFO; minimum latency is 2 cycles.
// TESTING
// - Single read: reset, then req READ id=3 addr=0x1000.
//   - l2_req_pkt.valid=1, id=3, at N+2 (N+1 with bypass).
//   - L2 responds data=0xAB.. id=3, so rsp_pkt id=3 appears 1 cycle later.
//   - drained returns to 1.
// - Fill: DEPTH=4 and MAX_OUTST=2, withhold responses, push 6 READs (ids 0-5).
//   - Exactly ids 0,1 issue; queue holds ids 2-5; req_rdy=0 after 4 remain queued.
//   - Respond id0: id2 issues the next cycle.
// - Write bypasses credit: outst_cnt=2, head=WRITE addr=0x40.
//   - WRITE issues immediately; a READ behind it waits for a response.
// - Simultaneous events: issue a READ in the same cycle an L2 response arrives.
//   - outst_cnt unchanged; a push+pop at count=2 leaves count=2.
//   - Pointer wrap is exercised by 3*DEPTH back-to-back writes with no loss or reorder.
// - Drain: assert drain with 2 queued and 1 in flight.
//   - req_rdy=0 immediately; drained=1 one cycle after the final response.
//   - Assert reset_n=0 mid-drain: all outputs go to 0 asynchronously and drained=1.

Source files
------------

// File: rtl/l2_req_q.sv
// Per-requester request queue between a cache and one L2 port: in-order FIFO issue with read
// credit throttling and a registered response path. Define L2Q_BYPASS_EN for empty-queue bypass.
module l2_req_q #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // request from cache
  input  logic              req_pkt_valid,
  input  logic [1:0]        req_pkt_op,
  input  logic [ID_W-1:0]   req_pkt_id,
  input  logic [ADDR_W-1:0] req_pkt_addr,
  input  logic [DATA_W-1:0] req_pkt_data,
  output logic              req_rdy,
  // request to L2
  output logic              l2_req_pkt_valid,
  output logic [1:0]        l2_req_pkt_op,
  output logic [ID_W-1:0]   l2_req_pkt_id,
  output logic [ADDR_W-1:0] l2_req_pkt_addr,
  output logic [DATA_W-1:0] l2_req_pkt_data,
  // response from L2
  input  logic              l2_rsp_pkt_valid,
  input  logic [ID_W-1:0]   l2_rsp_pkt_id,
  input  logic [DATA_W-1:0] l2_rsp_pkt_data,
  // response to cache
  output logic              rsp_pkt_valid,
  output logic [ID_W-1:0]   rsp_pkt_id,
  output logic [DATA_W-1:0] rsp_pkt_data,
  // drain control
  input  logic              drain,
  output logic              drained
);

  localparam logic [1:0] MEM_OP_READ     = 2'd0;
  localparam logic [1:0] MEM_OP_WRITE    = 2'd1;
  localparam logic [1:0] MEM_OP_READ_INV = 2'd2;

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned OutW = $clog2(MAX_OUTST + 1);
  localparam int unsigned EntW = 2 + ID_W + ADDR_W + DATA_W;

  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
  localparam logic [PtrW-1:0] DepthCnt = PtrW'(DEPTH);
  localparam logic [OutW-1:0] OutOne   = OutW'(1);
  localparam logic [OutW-1:0] OutMax   = OutW'(MAX_OUTST);

  function automatic logic is_read(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_READ_INV);
  endfunction

  // Storage and state
  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] count_q, count_d;
  logic [OutW-1:0] outst_cnt_q, outst_cnt_d;
  logic            req_rdy_q, req_rdy_d;
  logic            drained_q, drained_d;

  logic              l2_valid_q, l2_valid_d;
  logic [EntW-1:0]   l2_ent_q, l2_ent_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Datapath decisions
  logic            fifo_empty;
  logic            credit_ok;
  logic            push;
  logic            pop;
  logic            byp;
  logic            wr_en;
  logic            issue;
  logic            issue_rd;
  logic            rsp_ok;
  logic [EntW-1:0] req_entry;
  logic [EntW-1:0] head_entry;
  logic [EntW-1:0] issue_entry;
  logic [1:0]      head_op;

  assign req_entry  = {req_pkt_op, req_pkt_id, req_pkt_addr, req_pkt_data};
  assign head_entry = mem_q[rd_ptr_q[IdxW-1:0]];
  assign head_op    = head_entry[EntW-1 -: 2];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign credit_ok  = (outst_cnt_q < OutMax);
  assign req_rdy    = req_rdy_q & ~drain;
  assign push       = req_pkt_valid & req_rdy;
  assign pop        = ~fifo_empty & ((head_op == MEM_OP_WRITE) | credit_ok);

`ifdef L2Q_BYPASS_EN
  // An empty queue cannot pop, so an eligible request may skip storage entirely.
  assign byp = push & fifo_empty & ((req_pkt_op == MEM_OP_WRITE) | credit_ok);
`else
  assign byp = 1'b0;
`endif

  assign wr_en       = push & ~byp;
  assign issue       = pop | byp;
  assign issue_entry = byp ? req_entry : head_entry;
  assign issue_rd    = issue & is_read(issue_entry[EntW-1 -: 2]);
  // Responses with no credit outstanding are stale (e.g. arrived after a reset) and dropped.
  assign rsp_ok      = l2_rsp_pkt_valid & (outst_cnt_q != '0);

  always_comb begin
    wr_ptr_d = wr_en ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + PtrOne;
    end else if (!wr_en && pop) begin
      count_d = count_q - PtrOne;
    end

    outst_cnt_d = outst_cnt_q;
    if (issue_rd && !rsp_ok) begin
      outst_cnt_d = outst_cnt_q + OutOne;
    end else if (!issue_rd && rsp_ok) begin
      outst_cnt_d = outst_cnt_q - OutOne;
    end

    req_rdy_d = (count_d < DepthCnt) & ~drain;
    drained_d = (count_d == '0) & (outst_cnt_d == '0);

    l2_valid_d = issue;
    l2_ent_d   = issue ? issue_entry : '0;

    rsp_valid_d = rsp_ok;
    rsp_id_d    = rsp_ok ? l2_rsp_pkt_id : '0;
    rsp_data_d  = rsp_ok ? l2_rsp_pkt_data : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      outst_cnt_q <= '0;
      req_rdy_q   <= 1'b0;
      drained_q   <= 1'b1;
      l2_valid_q  <= 1'b0;
      l2_ent_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      outst_cnt_q <= outst_cnt_d;
      req_rdy_q   <= req_rdy_d;
      drained_q   <= drained_d;
      l2_valid_q  <= l2_valid_d;
      l2_ent_q    <= l2_ent_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[IdxW-1:0]] <= req_entry;
    end
  end

  assign l2_req_pkt_valid = l2_valid_q;
  assign l2_req_pkt_op    = l2_ent_q[EntW-1 -: 2];
  assign l2_req_pkt_id    = l2_ent_q[ADDR_W+DATA_W +: ID_W];
  assign l2_req_pkt_addr  = l2_ent_q[DATA_W +: ADDR_W];
  assign l2_req_pkt_data  = l2_ent_q[DATA_W-1:0];

  assign rsp_pkt_valid = rsp_valid_q;
  assign rsp_pkt_id    = rsp_id_q;
  assign rsp_pkt_data  = rsp_data_q;
  assign drained       = drained_q;

`ifdef ASSERT
  `define VASSERT(name, prop) \
    name: assert property (@(posedge clk) disable iff (!reset_n) (prop));
  `VASSERT(a_rsp_without_credit, !(l2_rsp_pkt_valid && (outst_cnt_q == '0)))
  `VASSERT(a_outst_bounded, outst_cnt_q <= OutMax)
  `VASSERT(a_count_bounded, count_q <= DepthCnt)
  `undef VASSERT
`endif

endmodule

// File: tb/tb_l2_req_q.sv
// Directed self-checking bench for l2_req_q (default build, DEPTH=4, MAX_OUTST=2).
module tb_l2_req_q;

  localparam logic [1:0] OpRd = 2'd0;
  localparam logic [1:0] OpWr = 2'd1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_pkt_valid;
  logic [1:0]  req_pkt_op;
  logic [3:0]  req_pkt_id;
  logic [31:0] req_pkt_addr;
  logic [31:0] req_pkt_data;
  logic        req_rdy;
  logic        l2_req_pkt_valid;
  logic [1:0]  l2_req_pkt_op;
  logic [3:0]  l2_req_pkt_id;
  logic [31:0] l2_req_pkt_addr;
  logic [31:0] l2_req_pkt_data;
  logic        l2_rsp_pkt_valid;
  logic [3:0]  l2_rsp_pkt_id;
  logic [31:0] l2_rsp_pkt_data;
  logic        rsp_pkt_valid;
  logic [3:0]  rsp_pkt_id;
  logic [31:0] rsp_pkt_data;
  logic        drain;
  logic        drained;

  int n_checks = 0;
  int n_errors = 0;

  l2_req_q #(
    .DEPTH     (4),
    .MAX_OUTST (2),
    .ID_W      (4),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_pkt_valid    (req_pkt_valid),
    .req_pkt_op       (req_pkt_op),
    .req_pkt_id       (req_pkt_id),
    .req_pkt_addr     (req_pkt_addr),
    .req_pkt_data     (req_pkt_data),
    .req_rdy          (req_rdy),
    .l2_req_pkt_valid (l2_req_pkt_valid),
    .l2_req_pkt_op    (l2_req_pkt_op),
    .l2_req_pkt_id    (l2_req_pkt_id),
    .l2_req_pkt_addr  (l2_req_pkt_addr),
    .l2_req_pkt_data  (l2_req_pkt_data),
    .l2_rsp_pkt_valid (l2_rsp_pkt_valid),
    .l2_rsp_pkt_id    (l2_rsp_pkt_id),
    .l2_rsp_pkt_data  (l2_rsp_pkt_data),
    .rsp_pkt_valid    (rsp_pkt_valid),
    .rsp_pkt_id       (rsp_pkt_id),
    .rsp_pkt_data     (rsp_pkt_data),
    .drain            (drain),
    .drained          (drained)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] op, input logic [3:0] id,
                         input logic [31:0] addr, input logic [31:0] data);
    req_pkt_valid = v;
    req_pkt_op    = op;
    req_pkt_id    = id;
    req_pkt_addr  = addr;
    req_pkt_data  = data;
  endtask

  // Expect an L2 issue of the given id/op this cycle.
  task automatic expect_issue(input string tag, input logic [3:0] id, input logic [1:0] op);
    check_eq({tag, "_valid"}, l2_req_pkt_valid, 1'b1);
    check_eq({tag, "_id"}, l2_req_pkt_id, id);
    check_eq({tag, "_op"}, l2_req_pkt_op, op);
  endtask

  // One-cycle L2 response, then check the registered copy toward the cache.
  task automatic respond(input logic [3:0] id);
    l2_rsp_pkt_valid = 1'b1;
    l2_rsp_pkt_id    = id;
    l2_rsp_pkt_data  = 32'hABCD_0000 | 32'(id);
    step();
    l2_rsp_pkt_valid = 1'b0;
    check_eq("rsp_valid", rsp_pkt_valid, 1'b1);
    check_eq("rsp_id", rsp_pkt_id, id);
    check_eq("rsp_data", rsp_pkt_data, 32'hABCD_0000 | 32'(id));
  endtask

  initial begin
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    l2_rsp_pkt_valid = 1'b0;
    l2_rsp_pkt_id    = '0;
    l2_rsp_pkt_data  = '0;
    drain            = 1'b0;

    // Reset state
    #1 reset_n = 1'b0;
    #2;
    check_eq("rst_req_rdy", req_rdy, 1'b0);
    check_eq("rst_drained", drained, 1'b1);
    check_eq("rst_l2_valid", l2_req_pkt_valid, 1'b0);
    check_eq("rst_rsp_valid", rsp_pkt_valid, 1'b0);
    step();
    step();
    check_eq("rst_hold_rdy", req_rdy, 1'b0);
    reset_n = 1'b1;
    step();
    check_eq("post_rst_rdy", req_rdy, 1'b1);
    check_eq("post_rst_drained", drained, 1'b1);

    // Single read: issue at N+2, response one cycle after L2 returns it
    set_req(1'b1, OpRd, 4'd3, 32'h1000, 32'd0);
    step();
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    check_eq("rd1_n1_valid", l2_req_pkt_valid, 1'b0);
    check_eq("rd1_busy", drained, 1'b0);
    step();
    expect_issue("rd1_n2", 4'd3, OpRd);
    check_eq("rd1_addr", l2_req_pkt_addr, 32'h1000);
    step();
    check_eq("rd1_pulse", l2_req_pkt_valid, 1'b0);
    respond(4'd3);
    check_eq("rd1_drained", drained, 1'b1);
    step();
    check_eq("rd1_rsp_pulse", rsp_pkt_valid, 1'b0);

    // Fill: 6 reads, only ids 0,1 issue, queue fills to DEPTH
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, OpRd, 4'(i), 32'h2000 + 32'(i * 64), 32'd0);
      step();
      if (i == 1 || i == 2) begin
        expect_issue("fill_issue", 4'(i - 1), OpRd);
      end else begin
        check_eq("fill_noissue", l2_req_pkt_valid, 1'b0);
      end
    end
    check_eq("fill_full_rdy", req_rdy, 1'b0);
    set_req(1'b1, OpRd, 4'd9, 32'h9999, 32'd0);
    step();
    step();
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    check_eq("fill_blocked", l2_req_pkt_valid, 1'b0);
    check_eq("fill_still_full", req_rdy, 1'b0);
    respond(4'd0);
    step();
    expect_issue("fill_id2", 4'd2, OpRd);
    check_eq("fill_rdy_back", req_rdy, 1'b1);
    for (int r = 1; r < 4; r++) begin
      respond(4'(r));
      step();
      expect_issue("fill_next", 4'(r + 2), OpRd);
    end
    respond(4'd4);
    respond(4'd5);
    check_eq("fill_drained", drained, 1'b1);

    // Write needs no credit; read behind it waits
    set_req(1'b1, OpRd, 4'd6, 32'h3000, 32'd0);
    step();
    set_req(1'b1, OpRd, 4'd7, 32'h3040, 32'd0);
    step();
    expect_issue("wr_r6", 4'd6, OpRd);
    set_req(1'b1, OpWr, 4'd8, 32'h40, 32'hDEAD_BEEF);
    step();
    expect_issue("wr_r7", 4'd7, OpRd);
    set_req(1'b1, OpRd, 4'd9, 32'h3080, 32'd0);
    step();
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    expect_issue("wr_w8", 4'd8, OpWr);
    check_eq("wr_addr", l2_req_pkt_addr, 32'h40);
    check_eq("wr_data", l2_req_pkt_data, 32'hDEAD_BEEF);
    step();
    check_eq("wr_r9_wait1", l2_req_pkt_valid, 1'b0);
    step();
    check_eq("wr_r9_wait2", l2_req_pkt_valid, 1'b0);
    respond(4'd6);
    step();
    expect_issue("wr_r9", 4'd9, OpRd);

    // Simultaneous issue + response, and push+pop at count=2
    set_req(1'b1, OpRd, 4'd10, 32'h4000, 32'd0);
    step();
    check_eq("sim_a", l2_req_pkt_valid, 1'b0);
    set_req(1'b1, OpRd, 4'd11, 32'h4040, 32'd0);
    step();
    check_eq("sim_b", l2_req_pkt_valid, 1'b0);
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    respond(4'd7);
    set_req(1'b1, OpRd, 4'd12, 32'h4080, 32'd0);
    l2_rsp_pkt_valid = 1'b1;
    l2_rsp_pkt_id    = 4'd9;
    l2_rsp_pkt_data  = 32'h0000_0909;
    step();
    l2_rsp_pkt_valid = 1'b0;
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    expect_issue("sim_r10", 4'd10, OpRd);
    check_eq("sim_rsp_id", rsp_pkt_id, 4'd9);
    check_eq("sim_rsp_data", rsp_pkt_data, 32'h0000_0909);
    step();
    expect_issue("sim_r11", 4'd11, OpRd);
    step();
    check_eq("sim_r12_wait1", l2_req_pkt_valid, 1'b0);
    step();
    check_eq("sim_r12_wait2", l2_req_pkt_valid, 1'b0);
    respond(4'd10);
    step();
    expect_issue("sim_r12", 4'd12, OpRd);
    respond(4'd11);
    respond(4'd12);
    check_eq("sim_drained", drained, 1'b1);

    // Pointer wrap: 3*DEPTH back-to-back writes, in order with no loss
    for (int c = 0; c < 13; c++) begin
      if (c < 12) begin
        set_req(1'b1, OpWr, 4'(c), 32'h400 + 32'(c * 4), 32'h5000 + 32'(c));
      end else begin
        set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
      end
      step();
      if (c >= 1) begin
        expect_issue("wrap", 4'(c - 1), OpWr);
        check_eq("wrap_data", l2_req_pkt_data, 32'h5000 + 32'(c - 1));
      end
    end
    step();
    check_eq("wrap_idle", l2_req_pkt_valid, 1'b0);
    check_eq("wrap_drained", drained, 1'b1);

    // Drain with 2 queued and 1 in flight
    set_req(1'b1, OpRd, 4'd1, 32'h6000, 32'd0);
    step();
    set_req(1'b1, OpRd, 4'd2, 32'h6040, 32'd0);
    step();
    expect_issue("dr_r1", 4'd1, OpRd);
    set_req(1'b1, OpRd, 4'd3, 32'h6080, 32'd0);
    step();
    expect_issue("dr_r2", 4'd2, OpRd);
    set_req(1'b1, OpRd, 4'd4, 32'h60C0, 32'd0);
    step();
    drain = 1'b1;
    set_req(1'b1, OpRd, 4'd15, 32'hFFFF, 32'd0);
    l2_rsp_pkt_valid = 1'b1;
    l2_rsp_pkt_id    = 4'd1;
    l2_rsp_pkt_data  = 32'hABCD_0001;
    #1;
    check_eq("dr_rdy_now", req_rdy, 1'b0);
    step();
    l2_rsp_pkt_valid = 1'b0;
    check_eq("dr_rsp1", rsp_pkt_id, 4'd1);
    check_eq("dr_busy1", drained, 1'b0);
    check_eq("dr_rdy_held", req_rdy, 1'b0);
    step();
    expect_issue("dr_r3", 4'd3, OpRd);
    respond(4'd2);
    step();
    expect_issue("dr_r4", 4'd4, OpRd);
    check_eq("dr_busy2", drained, 1'b0);
    respond(4'd3);
    check_eq("dr_busy3", drained, 1'b0);
    respond(4'd4);
    check_eq("dr_drained", drained, 1'b1);
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    check_eq("dr_no_r15", l2_req_pkt_valid, 1'b0);
    drain = 1'b0;
    #1;
    check_eq("undrain_now", req_rdy, 1'b0);
    step();
    check_eq("undrain_next", req_rdy, 1'b1);

    // Reset in the middle of a drain
    set_req(1'b1, OpRd, 4'd5, 32'h7000, 32'd0);
    step();
    set_req(1'b1, OpRd, 4'd6, 32'h7040, 32'd0);
    step();
    expect_issue("rd_r5", 4'd5, OpRd);
    set_req(1'b0, OpRd, 4'd0, 32'd0, 32'd0);
    drain            = 1'b1;
    l2_rsp_pkt_valid = 1'b1;
    l2_rsp_pkt_id    = 4'd5;
    l2_rsp_pkt_data  = 32'h0000_0055;
    step();
    l2_rsp_pkt_valid = 1'b0;
    expect_issue("rd_r6", 4'd6, OpRd);
    check_eq("rd_rsp5", rsp_pkt_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_l2_valid", l2_req_pkt_valid, 1'b0);
    check_eq("arst_l2_id", l2_req_pkt_id, 4'd0);
    check_eq("arst_l2_addr", l2_req_pkt_addr, 32'd0);
    check_eq("arst_rsp_valid", rsp_pkt_valid, 1'b0);
    check_eq("arst_rsp_data", rsp_pkt_data, 32'd0);
    check_eq("arst_req_rdy", req_rdy, 1'b0);
    check_eq("arst_drained", drained, 1'b1);
    drain   = 1'b0;
    reset_n = 1'b1;
    step();
    check_eq("arst_rel_rdy", req_rdy, 1'b1);
    check_eq("arst_rel_drained", drained, 1'b1);
    // Late response for pre-reset read is dropped
    l2_rsp_pkt_valid = 1'b1;
    l2_rsp_pkt_id    = 4'd6;
    l2_rsp_pkt_data  = 32'h0000_0066;
    step();
    l2_rsp_pkt_valid = 1'b0;
    check_eq("late_rsp_dropped", rsp_pkt_valid, 1'b0);
    check_eq("late_drained", drained, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
